// File: rtl/ro_sweep_ctrl.sv
// rtl/ro_sweep_ctrl.sv - ring oscillator tap sweep and edge-count measurement sequencer
// Optional RO_SWEEP_LOOP_EN: restart the sweep at TAP_FIRST after the last tap while start stays high.
module ro_sweep_ctrl #(
  parameter int TAP_FIRST = 2,
  parameter int TAP_LAST  = 15,
  parameter int FLUSH     = 4,
  parameter int SETTLE    = 16,
  parameter int WINDOW    = 1024,
  parameter int CNT_W     = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             ring_div_in,
  output logic [3:0]       clksel_out,
  output logic             ring_ena_out,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_tap,
  output logic [CNT_W-1:0] res_count,
  output logic             res_sat,
  output logic             done
);

  localparam int MAX_FS = (FLUSH > SETTLE) ? FLUSH : SETTLE;
  localparam int MAX_C  = (MAX_FS > WINDOW) ? MAX_FS : WINDOW;
  localparam int TW     = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_SETTLE,
    S_MEASURE,
    S_REPORT
  } state_t;

  state_t           state;
  logic [TW-1:0]    cnt;
  logic [3:0]       tap;
  logic [CNT_W-1:0] edge_cnt;
  logic             edge_sat;
  logic             sync1, sync2, sync3;
  logic             rise;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sat_nxt;

  // sync1/sync2 resolve metastability; sync3 holds the previous sample for edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= ring_div_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise = sync2 & ~sync3;

  always_comb begin
    cnt_nxt = edge_cnt;
    sat_nxt = edge_sat;
    if (rise) begin
      if (edge_cnt == {CNT_W{1'b1}}) sat_nxt = 1'b1;
      else cnt_nxt = edge_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      tap          <= '0;
      edge_cnt     <= '0;
      edge_sat     <= 1'b0;
      clksel_out   <= '0;
      ring_ena_out <= 1'b0;
      busy         <= 1'b0;
      res_valid    <= 1'b0;
      res_tap      <= '0;
      res_count    <= '0;
      res_sat      <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state        <= S_IDLE;
        cnt          <= '0;
        clksel_out   <= '0;
        ring_ena_out <= 1'b0;
        busy         <= 1'b0;
        res_valid    <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state      <= S_FLUSH;
              tap        <= 4'(TAP_FIRST);
              clksel_out <= 4'(TAP_FIRST);
              busy       <= 1'b1;
              cnt        <= '0;
            end
          end
          S_FLUSH: begin
            if (cnt == TW'(FLUSH - 1)) begin
              state        <= S_SETTLE;
              ring_ena_out <= 1'b1;
              cnt          <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_SETTLE: begin
            edge_cnt <= '0;
            edge_sat <= 1'b0;
            if (cnt == TW'(SETTLE - 1)) begin
              state <= S_MEASURE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_MEASURE: begin
            edge_cnt <= cnt_nxt;
            edge_sat <= sat_nxt;
            // the final window cycle's edge is folded into the reported result
            if (cnt == TW'(WINDOW - 1)) begin
              state        <= S_REPORT;
              res_tap      <= tap;
              res_count    <= cnt_nxt;
              res_sat      <= sat_nxt;
              res_valid    <= 1'b1;
              ring_ena_out <= 1'b0;
              cnt          <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_REPORT: begin
            if (res_ready) begin
              res_valid <= 1'b0;
              if (tap == 4'(TAP_LAST)) begin
                done <= 1'b1;
`ifdef RO_SWEEP_LOOP_EN
                if (start) begin
                  state      <= S_FLUSH;
                  tap        <= 4'(TAP_FIRST);
                  clksel_out <= 4'(TAP_FIRST);
                end else begin
                  state      <= S_IDLE;
                  clksel_out <= '0;
                  busy       <= 1'b0;
                end
`else
                state      <= S_IDLE;
                clksel_out <= '0;
                busy       <= 1'b0;
`endif
              end else begin
                state      <= S_FLUSH;
                tap        <= tap + 4'd1;
                clksel_out <= tap + 4'd1;
              end
            end
          end
          default: begin
            state        <= S_IDLE;
            clksel_out   <= '0;
            ring_ena_out <= 1'b0;
            busy         <= 1'b0;
            res_valid    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
